// File: rtl/lsu_align_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_align_ctrl
// Load/store alignment controller between the MEM stage and a word-organised
// data memory. It takes one byte-addressed request at a time and turns it into
// one or two word-aligned accesses with byte enables. For a load, it merges the
// returned words, shifts the bytes into place and sign/zero-extends the result.
//
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   req_valid/ready: request handshake; ready only while idle
//   req_we         : 1 = store, 0 = load
//   req_funct3     : access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr       : byte address
//   req_wdata      : right-justified store data
//   mem_re/mem_we  : memory read/write strobes (never both high)
//   mem_addr       : word-aligned byte address
//   mem_be         : per-lane byte enables
//   mem_wdata      : lane-positioned store data
//   mem_rdata      : read data, valid the cycle after mem_re
//   rsp_valid      : one-cycle completion pulse
//   rsp_rdata      : extended load result (0 for stores and errors)
//   rsp_err        : unsupported funct3, qualified by rsp_valid
// ---------------------------------------------------------------------------
module lsu_align_ctrl #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_we;
  logic [2:0]            r_funct3;
  logic [DM_ADDRESS-1:0] r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_lo;
  logic                  r_err;

  logic                  w_req_err;
  logic [1:0]            w_off;
  logic [3:0]            w_mask;
  logic [7:0]            w_be_full;
  logic                  w_split;
  logic [2*DATA_W-1:0]   w_wdata_sh;
  logic [DM_ADDRESS-3:0] w_word_inc;
  logic [DATA_W-1:0]     w_lo;
  logic [DATA_W-1:0]     w_hi;
  logic [DATA_W-1:0]     w_shifted;
  logic [DATA_W-1:0]     w_ext;

  // Error decode on the incoming request, used only to pick the next state.
  always_comb begin
    if (req_we) begin
      w_req_err = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      w_req_err = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end
  end

  // Size mask from the latched request: funct3[1:0] encodes 1, 2 or 4 bytes.
  always_comb begin
    case (r_funct3[1:0])
      2'b00:   w_mask = 4'b0001;
      2'b01:   w_mask = 4'b0011;
      default: w_mask = 4'b1111;
    endcase
  end

  assign w_off      = r_addr[1:0];
  // Lanes 3:0 belong to the first word, lanes 7:4 spill into the next word;
  // any spilled lane means the access crosses the word boundary.
  assign w_be_full  = {4'b0000, w_mask} << w_off;
  assign w_split    = |w_be_full[7:4];
  // Lower half is word-0 store data, upper half is the spill for word 1.
  assign w_wdata_sh = {{DATA_W{1'b0}}, r_wdata} << {w_off, 3'b000};
  // Word index wraps naturally at the top of memory.
  assign w_word_inc = r_addr[DM_ADDRESS-1:2] + {{(DM_ADDRESS-3){1'b0}}, 1'b1};

  // In DONE, mem_rdata holds the last word read (word 1 if split).
  assign w_lo      = w_split ? r_lo : mem_rdata;
  assign w_hi      = w_split ? mem_rdata : '0;
  assign w_shifted = DATA_W'({w_hi, w_lo} >> {w_off, 3'b000});

  always_comb begin
    case (r_funct3)
      3'b000:  w_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_ext = {24'd0, w_shifted[7:0]};
      3'b101:  w_ext = {16'd0, w_shifted[15:0]};
      default: w_ext = w_shifted;
    endcase
  end

  // Next state and outputs; all mem_* depend on registered state only.
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_be       = '0;
    mem_wdata    = '0;
    rsp_valid    = 1'b0;
    rsp_rdata    = '0;
    rsp_err      = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_next = w_req_err ? S_DONE : S_ACC0;
        end
      end
      S_ACC0: begin
        mem_re   = !r_we;
        mem_we   = r_we;
        mem_addr = {r_addr[DM_ADDRESS-1:2], 2'b00};
        mem_be   = w_be_full[3:0];
        if (r_we) begin
          mem_wdata = w_wdata_sh[DATA_W-1:0];
        end
        w_state_next = w_split ? S_ACC1 : S_DONE;
      end
      S_ACC1: begin
        mem_re   = !r_we;
        mem_we   = r_we;
        mem_addr = {w_word_inc, 2'b00};
        mem_be   = w_be_full[7:4];
        if (r_we) begin
          mem_wdata = w_wdata_sh[2*DATA_W-1:DATA_W];
        end
        w_state_next = S_DONE;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        rsp_err   = r_err;
        if (!r_we && !r_err) begin
          rsp_rdata = w_ext;
        end
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_lo     <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && req_valid) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_err    <= w_req_err;
      end
      // Word 0 of a split load arrives while ACC1 issues the second read.
      if (r_state == S_ACC1 && !r_we) begin
        r_lo <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_lsu_align_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_align_ctrl
// Directed bench for lsu_align_ctrl. Expected memory accesses and responses
// are queued when each request is issued; a monitor on the falling edge pops
// and compares whenever the controller strobes memory or pulses rsp_valid.
// ---------------------------------------------------------------------------
module tb_lsu_align_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  lsu_align_ctrl #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  typedef struct {
    logic        we;
    logic [8:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } rsp_exp_t;

  mem_exp_t mem_q[$];
  rsp_exp_t rsp_q[$];
  mem_exp_t mon_m;
  rsp_exp_t mon_r;
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Word memory model: one-cycle read latency, byte-lane writes.
  logic [31:0] mem [0:127];
  bit          loaded = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!loaded) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
      mem[0]   <= 32'h44332211;
      mem[1]   <= 32'h88776655;
      mem[127] <= 32'hDEADBEEF;
      mem_rdata <= 32'h0;
      loaded   <= 1'b1;
    end else begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) mem[mem_addr[8:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
      if (mem_re) mem_rdata <= mem[mem_addr[8:2]];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_re && mem_we) begin
        checks++;
        errors++;
        $display("FAIL mem_strobes: re=%0b we=%0b, expected at most one", mem_re, mem_we);
      end else if (mem_re || mem_we) begin
        if (mem_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_unexpected: we=%0b addr=0x%03h be=%b, expected no access",
                   mem_we, mem_addr, mem_be);
        end else begin
          mon_m = mem_q.pop_front();
          $display("mem  we=%0b addr=0x%03h be=%b wdata=0x%08h", mem_we, mem_addr, mem_be, mem_wdata);
          chk("mem_we", {31'd0, mem_we}, {31'd0, mon_m.we});
          chk("mem_addr", {23'd0, mem_addr}, {23'd0, mon_m.addr});
          chk("mem_be", {28'd0, mem_be}, {28'd0, mon_m.be});
          if (mon_m.we) chk("mem_wdata", mem_wdata, mon_m.wdata);
        end
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: rdata=0x%08h err=%0b, expected no response", rsp_rdata, rsp_err);
        end else begin
          mon_r = rsp_q.pop_front();
          $display("rsp  rdata=0x%08h err=%0b lat=%0d", rsp_rdata, rsp_err, cyc - mon_r.acc);
          chk("rsp_rdata", rsp_rdata, mon_r.rdata);
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, mon_r.err});
          chk("rsp_latency", cyc - mon_r.acc, mon_r.lat);
        end
      end
    end
  end

  task automatic exp_mem(input logic we, input logic [8:0] a, input logic [3:0] be,
                         input logic [31:0] wd);
    mem_q.push_back('{we, a, be, wd});
  endtask

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [8:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee,
                       input int lat, input bit want_rsp);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout: got 0, expected 1 within 50 cycles");
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    if (want_rsp) rsp_q.push_back('{er, ee, lat, cyc});
    @(posedge clk);
    @(negedge clk);
    // Garbage while busy must be ignored.
    req_valid  = 1'b0;
    req_we     = ~we;
    req_funct3 = 3'b111;
    req_addr   = 9'h155;
    req_wdata  = 32'hFFFF_FFFF;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || mem_q.size() != 0 || !req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", rsp_q.size() + mem_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 9'h000;
    req_wdata  = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_strobes", {25'd0, mem_re, mem_we, rsp_valid, rsp_err, mem_be}, 32'd0);
    chk("reset_mem_addr", {23'd0, mem_addr}, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Aligned load.
    exp_mem(0, 9'h004, 4'b1111, 0);
    issue(0, 3'b010, 9'h004, 0, 32'h88776655, 0, 2, 1); drain();
    // Split halfword load and byte loads at the top lane.
    exp_mem(0, 9'h000, 4'b1000, 0); exp_mem(0, 9'h004, 4'b0001, 0);
    issue(0, 3'b001, 9'h003, 0, 32'h00005544, 0, 3, 1); drain();
    exp_mem(0, 9'h004, 4'b1000, 0);
    issue(0, 3'b000, 9'h007, 0, 32'hFFFFFF88, 0, 2, 1); drain();
    exp_mem(0, 9'h004, 4'b1000, 0);
    issue(0, 3'b100, 9'h007, 0, 32'h00000088, 0, 2, 1); drain();
    // Split word store, then readback.
    exp_mem(1, 9'h000, 4'b1100, 32'hCCDD0000); exp_mem(1, 9'h004, 4'b0011, 32'h0000AABB);
    issue(1, 3'b010, 9'h002, 32'hAABBCCDD, 0, 0, 3, 1); drain();
    exp_mem(0, 9'h000, 4'b1111, 0);
    issue(0, 3'b010, 9'h000, 0, 32'hCCDD2211, 0, 2, 1); drain();
    exp_mem(0, 9'h004, 4'b1111, 0);
    issue(0, 3'b010, 9'h004, 0, 32'h8877AABB, 0, 2, 1); drain();
    // Byte store and split halfword store.
    exp_mem(1, 9'h000, 4'b0010, 32'h00005A00);
    issue(1, 3'b000, 9'h001, 32'h0000005A, 0, 0, 2, 1); drain();
    exp_mem(1, 9'h000, 4'b1000, 32'hEF000000); exp_mem(1, 9'h004, 4'b0001, 32'h000000BE);
    issue(1, 3'b001, 9'h003, 32'h0000BEEF, 0, 0, 3, 1); drain();
    // Halfword loads (signed aligned-in-word, unsigned split) and byte load.
    exp_mem(0, 9'h000, 4'b1100, 0);
    issue(0, 3'b001, 9'h002, 0, 32'hFFFFEFDD, 0, 2, 1); drain();
    exp_mem(0, 9'h000, 4'b1000, 0); exp_mem(0, 9'h004, 4'b0001, 0);
    issue(0, 3'b101, 9'h003, 0, 32'h0000BEEF, 0, 3, 1); drain();
    exp_mem(0, 9'h000, 4'b0010, 0);
    issue(0, 3'b000, 9'h001, 0, 32'h0000005A, 0, 2, 1); drain();
    // Split word load wrapping from the top word to word 0.
    exp_mem(0, 9'h1FC, 4'b1100, 0); exp_mem(0, 9'h000, 4'b0011, 0);
    issue(0, 3'b010, 9'h1FE, 0, 32'h5A11DEAD, 0, 3, 1); drain();
    // Unsupported funct3 for load and store: no access, error after 1 cycle.
    issue(0, 3'b011, 9'h004, 0, 32'h0, 1, 1, 1); drain();
    issue(1, 3'b100, 9'h000, 32'h12345678, 32'h0, 1, 1, 1); drain();
    exp_mem(0, 9'h000, 4'b1111, 0);
    issue(0, 3'b010, 9'h000, 0, 32'hEFDD5A11, 0, 2, 1); drain();

    // Reset during ACC1 of a split load: no response, outputs cleared at once.
    exp_mem(0, 9'h000, 4'b1000, 0);
    issue(0, 3'b001, 9'h003, 0, 32'h0, 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_strobes", {25'd0, mem_re, mem_we, rsp_valid, rsp_err, mem_be}, 32'd0);
    chk("abort_mem_addr", {23'd0, mem_addr}, 32'd0);
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_mem_pending", mem_q.size(), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_idle_ready", {31'd0, req_ready}, 32'd1);
    exp_mem(0, 9'h004, 4'b1111, 0);
    issue(0, 3'b010, 9'h004, 0, 32'h8877AABE, 0, 2, 1); drain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
